pe_array_sequencer: RTL and testbench

Command-driven front/back end for `PE_Array`:
- accepts one operation command (instruction, algorithm, beat count);
- streams operand beats into the array's `data_in` lanes;
- tracks the array's fixed pipeline latency;
- collects `data_out` into a credit-protected result FIFO drained through a valid/ready stream.

It sits between the polynomial memory/DMA side and `PE_Array`, which has no stall input, so the sequencer never issues a beat whose result cannot be stored.

---
 rtl/pe_pkg.sv | 44 ++++
 rtl/pe_result_fifo.sv | 45 ++++
 rtl/pe_array_sequencer.sv | 107 ++++++++++
 tb/tb_pe_array_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE_Array operation and parameter-set encodings.
// PE_Array, the sequencer and the benches all import these types.
package pe_pkg;

    typedef enum logic [4:0] {
        MADD     = 5'd0,
        MSUB     = 5'd1,
        MMUL     = 5'd2,
        MSQR     = 5'd3,
        NTT      = 5'd4,
        INTT     = 5'd5,
        BFLY_CT  = 5'd6,
        BFLY_GS  = 5'd7,
        DCP1     = 5'd8,
        DCP3     = 5'd9,
        DCP4     = 5'd10,
        DCP5     = 5'd11,
        DCP10    = 5'd12,
        DCP11    = 5'd13,
        HINT     = 5'd14,
        USE_HINT = 5'd15,
        CMP_1    = 5'd16,
        CMP_2    = 5'd17,
        CMP_3    = 5'd18,
        CMP_4    = 5'd19,
        CMP_5    = 5'd20,
        CMP_6    = 5'd21,
        CMP_7    = 5'd22,
        CMP_8    = 5'd23,
        CMP_9    = 5'd24,
        CMP_10   = 5'd25,
        CMP_11   = 5'd26
    } pe_instr_t;

    typedef enum logic [4:0] {
        KEM_512  = 5'd0,
        KEM_768  = 5'd1,
        KEM_1024 = 5'd2,
        DSA_44   = 5'd3,
        DSA_65   = 5'd4,
        DSA_87   = 5'd5
    } pe_alg_t;

endpackage

// File: rtl/pe_result_fifo.sv
// First-word fall-through result FIFO with occupancy count.
// Storage is not reset; the read port is gated to zero while empty.
module pe_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          valid,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign rdata  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push && !do_pop) assert (count < CW'(DEPTH));
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_pop)      count <= count + 1'b1;
            else if (!push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/pe_array_sequencer.sv
// Command sequencer around PE_Array: issues operand beats only when the
// result FIFO has room for everything already in flight.
module pe_array_sequencer
    import pe_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int NUM        = 4,
    parameter int IN_NUM     = 3,
    parameter int OUT_NUM    = 2,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  pe_instr_t                              cmd_instr,
    input  pe_alg_t                                cmd_alg,
    input  logic [15:0]                            cmd_len,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM-1:0][IN_NUM-1:0][WIDTH-1:0]  in_data,
    output pe_instr_t                              pe_instr,
    output pe_alg_t                                pe_alg,
    output logic [NUM-1:0][IN_NUM-1:0][WIDTH-1:0]  pe_data_in,
    input  logic [NUM-1:0][OUT_NUM-1:0][WIDTH-1:0] pe_data_out,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [NUM-1:0][OUT_NUM-1:0][WIDTH-1:0] out_data,
    output logic                                   busy,
    output logic                                   done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [15:0]   beats_left;
    logic [LAT:0]  vld_pipe;
    logic [CW-1:0] inflight, fifo_count;
    logic [CW:0]   credit_used;
    logic          in_fire, drain_done;

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
    end

    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign in_ready    = (state == RUN) && (beats_left != 16'd0) &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign in_fire     = in_valid && in_ready;

    // Look ahead one pop so done lands in the cycle right after the last pop.
    assign drain_done  = (state == DRAIN) && (inflight == '0) &&
                         ((fifo_count == '0) || ((fifo_count == CW'(1)) && out_ready));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beats_left <= '0;
            vld_pipe   <= '0;
            pe_instr   <= MADD;
            pe_alg     <= KEM_512;
            pe_data_in <= '0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            pe_data_in <= in_fire ? in_data : '0;
            vld_pipe   <= {vld_pipe[LAT-1:0], in_fire};
            case (state)
                IDLE: if (cmd_valid) begin
                    pe_instr   <= cmd_instr;
                    pe_alg     <= cmd_alg;
                    beats_left <= cmd_len;
                    state      <= (cmd_len == 16'd0) ? DRAIN : RUN;
                end
                RUN: if (in_fire) begin
                    beats_left <= beats_left - 16'd1;
                    if (beats_left == 16'd1) state <= DRAIN;
                end
                DRAIN: if (drain_done) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    pe_result_fifo #(
        .W     (NUM*OUT_NUM*WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_pipe[LAT]),
        .wdata (pe_data_out),
        .pop   (out_ready),
        .rdata (out_data),
        .valid (out_valid),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer with a latency-3 PE_Array stub
// (data_out[i][j] = data_in[i][j] + i) and an in-order result scoreboard.
module tb_pe_array_sequencer;
    import pe_pkg::*;

    localparam int WIDTH = 24, NUM = 4, IN_NUM = 3, OUT_NUM = 2, LAT = 3, DEPTH = 8;

    typedef logic [NUM-1:0][IN_NUM-1:0][WIDTH-1:0]  in_t;
    typedef logic [NUM-1:0][OUT_NUM-1:0][WIDTH-1:0] out_t;

    logic      clk = 1'b0, rst = 1'b0;
    logic      cmd_valid = 1'b0, cmd_ready;
    pe_instr_t cmd_instr = MADD;
    pe_alg_t   cmd_alg = KEM_512;
    logic [15:0] cmd_len = '0;
    logic      in_valid = 1'b0, in_ready;
    in_t       in_data = '0;
    pe_instr_t pe_instr;
    pe_alg_t   pe_alg;
    in_t       pe_data_in;
    out_t      pe_data_out;
    logic      out_valid, out_ready = 1'b0;
    out_t      out_data;
    logic      busy, done;

    int n_chk = 0, n_fail = 0, n_out = 0, acc = 0, base = 0;
    out_t exp_q [$];

    always #5 clk = ~clk;

    pe_array_sequencer #(
        .WIDTH(WIDTH), .NUM(NUM), .IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM),
        .LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_alg(cmd_alg), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pe_instr(pe_instr), .pe_alg(pe_alg),
        .pe_data_in(pe_data_in), .pe_data_out(pe_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    function automatic out_t pe_model(in_t d);
        out_t o;
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < OUT_NUM; j++)
                o[i][j] = d[i][j] + WIDTH'(i);
        return o;
    endfunction

    function automatic in_t mk_beat(int n);
        in_t d;
        for (int i = 0; i < NUM; i++)
            for (int j = 0; j < IN_NUM; j++)
                d[i][j] = WIDTH'(n * 37 + i * 1000 + j * 7 + 5);
        return d;
    endfunction

    // PE_Array stub: LAT register stages.
    out_t stub_pipe [LAT];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < LAT; k++) stub_pipe[k] <= '0;
        end else begin
            stub_pipe[0] <= pe_model(pe_data_in);
            for (int k = 1; k < LAT; k++) stub_pipe[k] <= stub_pipe[k-1];
        end
    end
    assign pe_data_out = stub_pipe[LAT-1];

    task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshakes are stable from #1 after a rising edge, so sample mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) exp_q.push_back(pe_model(in_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("sb_extra", 1, 0);
                else begin
                    out_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", out_data, e);
                end
                n_out++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(pe_instr_t ins, pe_alg_t alg, int len);
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_instr = ins;
        cmd_alg   = alg;
        cmd_len   = 16'(len);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic stream_start(int b);
        base     = b;
        acc      = 0;
        in_data  = mk_beat(b);
        in_valid = 1'b1;
    endtask

    task automatic beat_step();
        logic fire;
        fire = in_valid && in_ready;
        step();
        if (fire) begin
            acc++;
            in_data = mk_beat(base + acc);
        end
    endtask

    task automatic wait_done(string tag, int limit);
        bit seen = 0;
        for (int c = 0; c < limit && !seen; c++) begin
            step();
            if (done) seen = 1;
        end
        chk(tag, seen, 1);
    endtask

    task automatic chk_reset_vals(string p);
        chk({p, "_cmd_ready"}, cmd_ready, 1);
        chk({p, "_in_ready"}, in_ready, 0);
        chk({p, "_pe_instr"}, pe_instr, MADD);
        chk({p, "_pe_alg"}, pe_alg, KEM_512);
        chk({p, "_pe_data_in"}, pe_data_in, 0);
        chk({p, "_out_valid"}, out_valid, 0);
        chk({p, "_out_data"}, out_data, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
    endtask

    initial begin
        in_t v1;
        int lat, n0, cyc;

        // Reset state
        #2;
        chk_reset_vals("rst0");
        step(); step();
        rst = 1'b1;
        step();

        // 1: single beat, latency and done timing
        send_cmd(MMUL, KEM_768, 1);
        chk("t1_busy", busy, 1);
        chk("t1_pe_instr", pe_instr, MMUL);
        chk("t1_in_ready", in_ready, 1);
        v1 = mk_beat(0);
        v1[0][0] = 24'd134;
        v1[0][1] = 24'd2;
        v1[1][0] = 24'hFFFFFF;
        v1[3][0] = 24'd1000;
        in_data = v1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_pe_data_in", pe_data_in, v1);
        lat = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (out_valid) begin lat = e; break; end
        end
        chk("t1_latency", lat, 4);
        chk("t1_out00", out_data[0][0], 134);
        chk("t1_out01", out_data[0][1], 2);
        chk("t1_out10_wrap", out_data[1][0], 0);
        chk("t1_out30", out_data[3][0], 1003);
        step();
        chk("t1_done", done, 1);
        chk("t1_out_valid_after_pop", out_valid, 0);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", cmd_ready, 1);
        chk("t1_pe_instr_hold", pe_instr, MMUL);
        chk("t1_nout", n_out, 1);

        // 2: streaming 16 beats at full rate
        n0 = n_out;
        send_cmd(DCP3, DSA_87, 16);
        stream_start(100);
        cyc = 0;
        while (acc < 16 && cyc < 100) begin
            beat_step();
            cyc++;
            chk("t2_pe_instr", pe_instr, DCP3);
            chk("t2_pe_alg", pe_alg, DSA_87);
        end
        chk("t2_cycles", cyc, 16);
        in_valid = 1'b0;
        step();
        chk("t2_pe_data_in_zero", pe_data_in, 0);
        chk("t2_in_ready_drain", in_ready, 0);
        wait_done("t2_done", 100);
        chk("t2_nout", n_out - n0, 16);
        chk("t2_alg_hold", pe_alg, DSA_87);

        // 3: backpressure, at most DEPTH beats with out_ready low
        n0 = n_out;
        out_ready = 1'b0;
        send_cmd(NTT, KEM_1024, 20);
        stream_start(300);
        for (int c = 0; c < 20; c++) beat_step();
        chk("t3_accepted", acc, 8);
        chk("t3_in_ready_low", in_ready, 0);
        chk("t3_nout_held", n_out - n0, 0);
        out_ready = 1'b1;
        cyc = 0;
        while (acc < 20 && cyc < 200) begin beat_step(); cyc++; end
        chk("t3_accepted_all", acc, 20);
        in_valid = 1'b0;
        wait_done("t3_done", 200);
        chk("t3_nout", n_out - n0, 20);
        chk("t3_q_empty", exp_q.size(), 0);

        // 4: zero-length command
        n0 = n_out;
        send_cmd(CMP_11, DSA_44, 0);
        chk("t4_busy", busy, 1);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_done_early", done, 0);
        step();
        chk("t4_done", done, 1);
        chk("t4_out_valid", out_valid, 0);
        step();
        chk("t4_done_pulse", done, 0);
        chk("t4_nout", n_out - n0, 0);

        // 6: simultaneous push/pop at count 3
        n0 = n_out;
        out_ready = 1'b0;
        send_cmd(MSUB, DSA_65, 12);
        stream_start(500);
        cyc = 0;
        while (dut.fifo_count != 4'd3 && cyc < 50) begin beat_step(); cyc++; end
        chk("t6_reach3", dut.fifo_count, 3);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            beat_step();
            chk("t6_count_hold", dut.fifo_count, 3);
        end
        cyc = 0;
        while (acc < 12 && cyc < 100) begin beat_step(); cyc++; end
        in_valid = 1'b0;
        wait_done("t6_done", 100);
        chk("t6_nout", n_out - n0, 12);

        // 5: reset mid-run, then a normal command
        out_ready = 1'b0;
        send_cmd(INTT, KEM_768, 10);
        stream_start(700);
        cyc = 0;
        while (acc < 5 && cyc < 50) begin beat_step(); cyc++; end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset_vals("t5");
        exp_q.delete();
        step(); step();
        rst = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t5_no_done", done, 0);
        end
        chk("t5_out_valid", out_valid, 0);
        chk("t5_nout_discard", n_out - n0, 0);
        send_cmd(MADD, DSA_44, 2);
        stream_start(900);
        cyc = 0;
        while (acc < 2 && cyc < 50) begin beat_step(); cyc++; end
        in_valid = 1'b0;
        wait_done("t5_done", 100);
        chk("t5_nout", n_out - n0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
